ex_branch_resolve_unit: RTL and testbench

Execute-stage datapath and branch-resolution block of the 5-stage ARM-subset pipeline. Contains:
- the 32-bit ALU (16 ARM data-processing opcodes, NZCV generation);
- the architectural flag register with S-controlled update;
- the condition evaluator;
- the branch target adder (PC+4 plus sign-extended word offset);
- the condition handler that produces the taken-branch and BL link-write strobes.

Its outputs feed the EX/MEM register, the IF PC-select mux, the IF/ID flush and the register-file link write.

---
 rtl/ex_branch_resolve_unit.sv | 121 ++++++++++++
 tb/tb_ex_branch_resolve_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ex_branch_resolve_unit.sv
// ex_branch_resolve_unit: EX-stage ALU, NZCV flag register, condition evaluator, branch target and strobes.
// Optional macro FLAG_BYPASS_EN: the condition evaluator sees this cycle's alu_flags when s_en=1.
`default_nettype none

module ex_branch_resolve_unit (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic        shift_cout,
  input  logic [3:0]  alu_op,
  input  logic        s_en,
  input  logic [3:0]  cond,
  input  logic [23:0] offset24,
  input  logic [31:0] pc4,
  input  logic        b_instr,
  input  logic        bl_instr,
  output logic [31:0] alu_out,
  output logic [3:0]  alu_flags,
  output logic [3:0]  flags_q,
  output logic        cond_true,
  output logic [31:0] target_addr,
  output logic        branch_taken,
  output logic        bl_link
);

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  logic [31:0] add_x, add_y;
  logic        add_cin;
  logic        is_arith;
  logic [32:0] sum;
  logic [31:0] logic_res;
  logic [3:0]  flags_d;
  logic [3:0]  eff_flags;
  logic        fn, fz, fc, fv;

  // Every add/sub maps onto one adder: subtraction adds the inverted operand plus carry-in.
  always_comb begin
    add_x    = alu_a;
    add_y    = alu_b;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (alu_op)
      OP_SUB, OP_CMP: begin add_x = alu_a; add_y = ~alu_b; add_cin = 1'b1;       end
      OP_RSB:         begin add_x = alu_b; add_y = ~alu_a; add_cin = 1'b1;       end
      OP_ADD, OP_CMN: begin add_x = alu_a; add_y = alu_b;  add_cin = 1'b0;       end
      OP_ADC:         begin add_x = alu_a; add_y = alu_b;  add_cin = flags_q[1]; end
      OP_SBC:         begin add_x = alu_a; add_y = ~alu_b; add_cin = flags_q[1]; end
      OP_RSC:         begin add_x = alu_b; add_y = ~alu_a; add_cin = flags_q[1]; end
      default:        is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

  always_comb begin
    logic_res = alu_a & alu_b;
    case (alu_op)
      OP_EOR, OP_TEQ: logic_res = alu_a ^ alu_b;
      OP_ORR:         logic_res = alu_a | alu_b;
      OP_MOV:         logic_res = alu_b;
      OP_BIC:         logic_res = alu_a & ~alu_b;
      OP_MVN:         logic_res = ~alu_b;
      default:        logic_res = alu_a & alu_b;
    endcase
  end

  assign alu_out   = is_arith ? sum[31:0] : logic_res;
  assign alu_flags = {alu_out[31],
                      (alu_out == 32'd0),
                      is_arith ? sum[32] : shift_cout,
                      is_arith ? ((add_x[31] == add_y[31]) && (sum[31] != add_x[31])) : flags_q[0]};

  assign flags_d = s_en ? alu_flags : flags_q;

  always_ff @(posedge CLK) begin
    if (CLR) flags_q <= 4'b0000;
    else     flags_q <= flags_d;
  end

`ifdef FLAG_BYPASS_EN
  assign eff_flags = s_en ? alu_flags : flags_q;
`else
  assign eff_flags = flags_q;
`endif

  assign {fn, fz, fc, fv} = eff_flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = fz;
      4'h1: cond_true = !fz;
      4'h2: cond_true = fc;
      4'h3: cond_true = !fc;
      4'h4: cond_true = fn;
      4'h5: cond_true = !fn;
      4'h6: cond_true = fv;
      4'h7: cond_true = !fv;
      4'h8: cond_true = fc && !fz;
      4'h9: cond_true = !fc || fz;
      4'hA: cond_true = (fn == fv);
      4'hB: cond_true = (fn != fv);
      4'hC: cond_true = !fz && (fn == fv);
      4'hD: cond_true = fz || (fn != fv);
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign target_addr  = pc4 + {{6{offset24[23]}}, offset24, 2'b00};
  assign branch_taken = b_instr && cond_true && !CLR;
  assign bl_link      = bl_instr && cond_true && !CLR;

endmodule

`default_nettype wire

// File: tb/tb_ex_branch_resolve_unit.sv
// Directed, table-driven bench for ex_branch_resolve_unit (either FLAG_BYPASS_EN build).
`default_nettype none

module tb_ex_branch_resolve_unit;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [31:0] alu_a, alu_b, pc4;
  logic        shift_cout, s_en, b_instr, bl_instr;
  logic [3:0]  alu_op, cond;
  logic [23:0] offset24;
  logic [31:0] alu_out, target_addr;
  logic [3:0]  alu_flags, flags_q;
  logic        cond_true, branch_taken, bl_link;

  int n_tests = 0;
  int n_fail  = 0;

  ex_branch_resolve_unit dut (
    .CLK(CLK), .CLR(CLR), .alu_a(alu_a), .alu_b(alu_b), .shift_cout(shift_cout),
    .alu_op(alu_op), .s_en(s_en), .cond(cond), .offset24(offset24), .pc4(pc4),
    .b_instr(b_instr), .bl_instr(bl_instr), .alu_out(alu_out), .alu_flags(alu_flags),
    .flags_q(flags_q), .cond_true(cond_true), .target_addr(target_addr),
    .branch_taken(branch_taken), .bl_link(bl_link)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sc;
    logic [3:0]  cnd;
    logic [31:0] exp_out;
    logic [3:0]  exp_flags;
    logic        exp_ct;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic se);
    alu_op = op; alu_a = a; alu_b = b; shift_cout = sc; s_en = se;
    #1;
  endtask

  logic bypass;

  initial begin
`ifdef FLAG_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    // Flags_q is 0000 while the table runs (s_en=0): cond expectations follow from NZCV=0000.
    vecs[0]  = '{4'h4, 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'h0, 32'h80000000, 4'b1001, 1'b0};
    vecs[1]  = '{4'h2, 32'h00000005, 32'h00000005, 1'b0, 4'h1, 32'h00000000, 4'b0110, 1'b1};
    vecs[2]  = '{4'hA, 32'h00000003, 32'h00000005, 1'b0, 4'h2, 32'hFFFFFFFE, 4'b1000, 1'b0};
    vecs[3]  = '{4'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 4'h3, 32'h00000000, 4'b0110, 1'b1};
    vecs[4]  = '{4'h1, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 4'h4, 32'hFFFFFFFF, 4'b1000, 1'b0};
    vecs[5]  = '{4'h3, 32'h00000001, 32'h00000000, 1'b0, 4'h5, 32'hFFFFFFFF, 4'b1000, 1'b1};
    vecs[6]  = '{4'h5, 32'h00000001, 32'h00000002, 1'b0, 4'h6, 32'h00000003, 4'b0000, 1'b0};
    vecs[7]  = '{4'h6, 32'h00000005, 32'h00000003, 1'b0, 4'h7, 32'h00000001, 4'b0010, 1'b1};
    vecs[8]  = '{4'h7, 32'h00000003, 32'h00000005, 1'b0, 4'h8, 32'h00000001, 4'b0010, 1'b0};
    vecs[9]  = '{4'h8, 32'h80000000, 32'h80000001, 1'b0, 4'h9, 32'h80000000, 4'b1000, 1'b1};
    vecs[10] = '{4'h9, 32'h12345678, 32'h12345678, 1'b0, 4'hA, 32'h00000000, 4'b0100, 1'b1};
    vecs[11] = '{4'hB, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'hB, 32'h00000000, 4'b0110, 1'b0};
    vecs[12] = '{4'hC, 32'h000000F0, 32'h00000F00, 1'b1, 4'hC, 32'h00000FF0, 4'b0010, 1'b1};
    vecs[13] = '{4'hD, 32'hDEADBEEF, 32'h00000000, 1'b0, 4'hD, 32'h00000000, 4'b0100, 1'b0};
    vecs[14] = '{4'hE, 32'h000000FF, 32'h0000000F, 1'b0, 4'hE, 32'h000000F0, 4'b0000, 1'b1};
    vecs[15] = '{4'hF, 32'h00000000, 32'h00000000, 1'b1, 4'hF, 32'hFFFFFFFF, 4'b1010, 1'b0};
    vecs[16] = '{4'h2, 32'h80000000, 32'h00000001, 1'b0, 4'hE, 32'h7FFFFFFF, 4'b0011, 1'b1};
    vecs[17] = '{4'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h0, 32'hFFFFFFFE, 4'b1010, 1'b0};

    CLR = 1'b1; s_en = 1'b0; cond = 4'hE; offset24 = '0; pc4 = '0;
    b_instr = 1'b1; bl_instr = 1'b1;
    drive(4'h4, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1);
    tick();
    check("reset_flags_q", {28'd0, flags_q}, 32'h0);
    tick();
    // Reset overrides a pending s_en write with nonzero alu_flags.
    check("reset_alu_flags_nonzero", {28'd0, alu_flags}, 32'h9);
    check("reset_flags_q_override", {28'd0, flags_q}, 32'h0);
    check("reset_branch_taken", {31'd0, branch_taken}, 32'h0);
    check("reset_bl_link", {31'd0, bl_link}, 32'h0);

    CLR = 1'b0; s_en = 1'b0; bl_instr = 1'b0;
    cond = 4'h0; #1; check("post_reset_EQ", {31'd0, cond_true}, 32'h0);
    cond = 4'h1; #1; check("post_reset_NE", {31'd0, cond_true}, 32'h1);
    cond = 4'hE; #1; check("post_reset_AL", {31'd0, cond_true}, 32'h1);

    for (int i = 0; i < 18; i++) begin
      cond = vecs[i].cnd;
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sc, 1'b0);
      check($sformatf("vec%0d_out", i), alu_out, vecs[i].exp_out);
      check($sformatf("vec%0d_flags", i), {28'd0, alu_flags}, {28'd0, vecs[i].exp_flags});
      check($sformatf("vec%0d_cond", i), {31'd0, cond_true}, {31'd0, vecs[i].exp_ct});
      check($sformatf("vec%0d_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].exp_ct});
    end
    tick();
    check("flags_hold_s_en0", {28'd0, flags_q}, 32'h0);

    drive(4'h4, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1);
    tick();
    check("add_flags_q", {28'd0, flags_q}, 32'h9);

    // CMP equal with s_en=1 and a B/BL in the same cycle: old flags_q=1001 has Z=0.
    b_instr = 1'b1; bl_instr = 1'b1;
    drive(4'hA, 32'h5, 32'h5, 1'b0, 1'b1);
    cond = 4'h0; #1;
    check("bypass_EQ_taken", {31'd0, branch_taken}, {31'd0, bypass});
    check("bypass_EQ_bl", {31'd0, bl_link}, {31'd0, bypass});
    cond = 4'h1; #1;
    check("bypass_NE_taken", {31'd0, branch_taken}, {31'd0, !bypass});
    check("bypass_NE_bl", {31'd0, bl_link}, {31'd0, !bypass});
    cond = 4'hF; #1;
    check("NV_taken", {31'd0, branch_taken}, 32'h0);
    check("NV_bl", {31'd0, bl_link}, 32'h0);
    tick();
    check("cmp_flags_q", {28'd0, flags_q}, 32'h6);

    b_instr = 1'b0; bl_instr = 1'b0;
    drive(4'h5, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    check("adc_cq1_out", alu_out, 32'h0);
    check("adc_cq1_flags", {28'd0, alu_flags}, 32'h6);

    drive(4'h2, 32'h80000000, 32'h1, 1'b0, 1'b1);
    tick();
    check("sub_ovf_flags_q", {28'd0, flags_q}, 32'h3);
    drive(4'hD, 32'h12345678, 32'h0, 1'b1, 1'b0);
    check("mov_vq_flags", {28'd0, alu_flags}, 32'h7);

    cond = 4'hE; bl_instr = 1'b1; b_instr = 1'b0; #1;
    check("bl_only_link", {31'd0, bl_link}, 32'h1);
    check("bl_only_taken", {31'd0, branch_taken}, 32'h0);
    bl_instr = 1'b0;

    pc4 = 32'h100; offset24 = 24'hFFFFFE; #1;
    check("target_neg", target_addr, 32'hF8);
    offset24 = 24'h000003; #1;
    check("target_pos", target_addr, 32'h10C);
    pc4 = 32'h0; offset24 = 24'h800000; #1;
    check("target_min", target_addr, 32'hFE000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
